load_store_unit: RTL and testbench



---
 rtl/load_store_unit_if.sv | 43 ++++
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 tb/tb_load_store_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit_if
// Brief   : Request/response handshake and RAM-side bus of the load/store unit.
// Revision: 1.0
// ============================================================================
interface load_store_unit_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqWHBS;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespRData;
    logic [1:0]  RespExc;
    logic        MemWE;
    logic [1:0]  MemRWHBS;
    logic [1:0]  MemWWHBS;
    logic [31:0] MemRADDR;
    logic [31:0] MemWADDR;
    logic [31:0] MemDIN;
    logic [31:0] MemDOUT;
    logic        MemRUnalExc;
    logic        MemWUnalExc;

    modport slave (
        input  ReqValid, ReqWrite, ReqWHBS, ReqSigned, ReqAddr, ReqWData,
        input  RespReady, MemDOUT, MemRUnalExc, MemWUnalExc,
        output ReqReady, RespValid, RespRData, RespExc,
        output MemWE, MemRWHBS, MemWWHBS, MemRADDR, MemWADDR, MemDIN
    );

    modport master (
        output ReqValid, ReqWrite, ReqWHBS, ReqSigned, ReqAddr, ReqWData,
        output RespReady, MemDOUT, MemRUnalExc, MemWUnalExc,
        input  ReqReady, RespValid, RespRData, RespExc,
        input  MemWE, MemRWHBS, MemWWHBS, MemRADDR, MemWADDR, MemDIN
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Brief   : Three-state load/store unit: checks, one RAM access cycle, response.
// Revision: 1.0
// ============================================================================
module load_store_unit #(
    parameter int RAM_BYTES = 1024
) (
    input  logic              CLK,
    input  logic              nRST,
    load_store_unit_if.slave  bus
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ACC       = 2'd1;
    localparam logic [1:0] c_RESP      = 2'd2;

    localparam logic [1:0] c_EXC_OK    = 2'b00;
    localparam logic [1:0] c_EXC_UNAL  = 2'b01;
    localparam logic [1:0] c_EXC_RANGE = 2'b10;
    localparam logic [1:0] c_EXC_SIZE  = 2'b11;

    localparam logic [1:0] c_SZ_BYTE   = 2'b00;
    localparam logic [1:0] c_SZ_HALF   = 2'b01;
    localparam logic [1:0] c_SZ_ILL    = 2'b10;
    localparam logic [1:0] c_SZ_WORD   = 2'b11;

    logic [1:0]  state_q,  state_d;
    logic        write_q,  write_d;
    logic [1:0]  whbs_q,   whbs_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] rdata_q,  rdata_d;
    logic [1:0]  exc_q,    exc_d;

    logic [32:0] w_last_byte;
    logic [1:0]  w_chk_exc;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    // Request checks, evaluated on the live request inputs at accept time.
    // The last-byte sum is 33 bits wide so addresses near 2^32 cannot wrap.
    always_comb begin
        w_last_byte = {1'b0, bus.ReqAddr};
        if (bus.ReqWHBS == c_SZ_WORD) begin
            w_last_byte = {1'b0, bus.ReqAddr} + 33'd3;
        end else if (bus.ReqWHBS == c_SZ_HALF) begin
            w_last_byte = {1'b0, bus.ReqAddr} + 33'd1;
        end

        w_chk_exc = c_EXC_OK;
        if (bus.ReqWHBS == c_SZ_ILL) begin
            w_chk_exc = c_EXC_SIZE;
        end else if ((bus.ReqWHBS == c_SZ_HALF && bus.ReqAddr[0]) ||
                     (bus.ReqWHBS == c_SZ_WORD && bus.ReqAddr[1:0] != 2'b00)) begin
            w_chk_exc = c_EXC_UNAL;
        end else if (w_last_byte >= 33'(RAM_BYTES)) begin
            w_chk_exc = c_EXC_RANGE;
        end
    end

    // Little-endian lane extraction from the aligned word read back in ACC.
    always_comb begin
        w_byte = bus.MemDOUT[{addr_q[1:0], 3'b000} +: 8];
        w_half = bus.MemDOUT[{addr_q[1], 4'b0000} +: 16];
        case (whbs_q)
            c_SZ_BYTE: w_load_data = signed_q ? {{24{w_byte[7]}}, w_byte}
                                              : {24'd0, w_byte};
            c_SZ_HALF: w_load_data = signed_q ? {{16{w_half[15]}}, w_half}
                                              : {16'd0, w_half};
            default:   w_load_data = bus.MemDOUT;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        whbs_d   = whbs_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        exc_d    = exc_q;

        case (state_q)
            c_IDLE: begin
                if (bus.ReqValid) begin
                    write_d  = bus.ReqWrite;
                    whbs_d   = bus.ReqWHBS;
                    signed_d = bus.ReqSigned;
                    addr_d   = bus.ReqAddr;
                    wdata_d  = bus.ReqWData;
                    rdata_d  = 32'd0;
                    exc_d    = w_chk_exc;
                    state_d  = (w_chk_exc == c_EXC_OK) ? c_ACC : c_RESP;
                end
            end
            c_ACC: begin
                state_d = c_RESP;
                if (write_q) begin
                    rdata_d = 32'd0;
                    exc_d   = bus.MemWUnalExc ? c_EXC_UNAL : c_EXC_OK;
                end else if (bus.MemRUnalExc) begin
                    rdata_d = 32'd0;
                    exc_d   = c_EXC_UNAL;
                end else begin
                    rdata_d = w_load_data;
                    exc_d   = c_EXC_OK;
                end
            end
            c_RESP: begin
                if (bus.RespReady) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= c_IDLE;
            write_q  <= 1'b0;
            whbs_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            exc_q    <= c_EXC_OK;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            whbs_q   <= whbs_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            exc_q    <= exc_d;
        end
    end

    // RAM strobes decode from the registered state only, so a store in ACC
    // still reaches the RAM on an edge where reset is asserted.
    always_comb begin
        bus.ReqReady  = (state_q == c_IDLE);
        bus.RespValid = (state_q == c_RESP);
        bus.RespRData = rdata_q;
        bus.RespExc   = exc_q;
        bus.MemWE     = 1'b0;
        bus.MemRWHBS  = 2'b00;
        bus.MemRADDR  = 32'd0;
        bus.MemWWHBS  = 2'b00;
        bus.MemWADDR  = 32'd0;
        bus.MemDIN    = 32'd0;
        if (state_q == c_ACC) begin
            bus.MemRWHBS = c_SZ_WORD;
            bus.MemRADDR = {addr_q[31:2], 2'b00};
            if (write_q) begin
                bus.MemWE    = 1'b1;
                bus.MemWWHBS = whbs_q;
                bus.MemWADDR = addr_q;
                case (whbs_q)
                    c_SZ_BYTE: bus.MemDIN = {4{wdata_q[7:0]}};
                    c_SZ_HALF: bus.MemDIN = {2{wdata_q[15:0]}};
                    default:   bus.MemDIN = wdata_q;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Directed + random bench with a byte-array reference model and RAM.
// Revision: 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int RAM_BYTES = 1024;

    logic CLK = 1'b0;
    logic nRST;
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   inj_r  = 1'b0;
    bit   inj_w  = 1'b0;

    logic [7:0] ram       [0:RAM_BYTES-1];
    logic [7:0] model_mem [0:RAM_BYTES-1];

    load_store_unit_if bus ();

    load_store_unit #(.RAM_BYTES(RAM_BYTES)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // Ram: combinational aligned-word read, byte-lane write on the rising edge.
    wire [9:0] w_ra = bus.MemRADDR[9:0];
    wire [9:0] w_wa = bus.MemWADDR[9:0];
    assign bus.MemDOUT = {ram[{w_ra[9:2], 2'd3}], ram[{w_ra[9:2], 2'd2}],
                          ram[{w_ra[9:2], 2'd1}], ram[{w_ra[9:2], 2'd0}]};
    assign bus.MemRUnalExc = inj_r;
    assign bus.MemWUnalExc = inj_w;

    always @(posedge CLK) begin
        if (bus.MemWE && !bus.MemWUnalExc) begin
            case (bus.MemWWHBS)
                2'b00: ram[w_wa] <= bus.MemDIN[8*w_wa[1:0] +: 8];
                2'b01: begin
                    ram[w_wa]         <= bus.MemDIN[16*w_wa[1] +: 8];
                    ram[w_wa + 10'd1] <= bus.MemDIN[16*w_wa[1] + 8 +: 8];
                end
                default: begin
                    ram[w_wa]         <= bus.MemDIN[7:0];
                    ram[w_wa + 10'd1] <= bus.MemDIN[15:8];
                    ram[w_wa + 10'd2] <= bus.MemDIN[23:16];
                    ram[w_wa + 10'd3] <= bus.MemDIN[31:24];
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction: reference expectation, drive, scramble inputs
    // after accept, check latency/data/exception, optional back-pressure.
    task automatic xact(input bit wr, input logic [1:0] whbs, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, input bit inj);
        int          size;
        int          exp_exc;
        int          exp_lat;
        int          n;
        logic [31:0] exp_data;
        logic [31:0] exp_din;

        size     = (whbs == 2'b11) ? 4 : (whbs == 2'b01) ? 2 : 1;
        exp_data = 32'd0;
        if (whbs == 2'b10)                               exp_exc = 3;
        else if ((int'(addr[1:0]) % size) != 0)          exp_exc = 1;
        else if (longint'(addr) + size > RAM_BYTES)      exp_exc = 2;
        else                                             exp_exc = 0;
        exp_lat = (exp_exc != 0) ? 1 : 2;
        exp_din = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;

        if (exp_exc == 0 && inj) begin
            exp_exc = 1;
        end else if (exp_exc == 0 && !wr) begin
            for (int i = 0; i < size; i++)
                exp_data = exp_data | (32'(model_mem[int'(addr) + i]) << (8 * i));
            if (sgn && size < 4 && exp_data[8*size-1])
                exp_data = exp_data | (32'hFFFF_FFFF << (8 * size));
        end else if (exp_exc == 0 && wr) begin
            for (int i = 0; i < size; i++)
                model_mem[int'(addr) + i] = wd[8*i +: 8];
        end

        @(negedge CLK);
        chk("req_ready_idle", 32'(bus.ReqReady), 32'd1);
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = wr;
        bus.ReqWHBS   = whbs;
        bus.ReqSigned = sgn;
        bus.ReqAddr   = addr;
        bus.ReqWData  = wd;
        inj_r = inj & !wr;
        inj_w = inj & wr;
        @(posedge CLK);
        @(negedge CLK);
        bus.ReqValid  = 1'b0;
        bus.ReqWrite  = 1'($urandom);
        bus.ReqWHBS   = 2'($urandom);
        bus.ReqSigned = 1'($urandom);
        bus.ReqAddr   = $urandom;
        bus.ReqWData  = $urandom;

        if (exp_lat == 2) begin
            chk("acc_we",    32'(bus.MemWE), 32'(wr));
            chk("acc_raddr", bus.MemRADDR, {addr[31:2], 2'b00});
            chk("acc_rwhbs", 32'(bus.MemRWHBS), 32'd3);
            if (wr) begin
                chk("acc_waddr", bus.MemWADDR, addr);
                chk("acc_wwhbs", 32'(bus.MemWWHBS), 32'(whbs));
                chk("acc_din",   bus.MemDIN, exp_din);
            end
        end else begin
            chk("exc_no_we", 32'(bus.MemWE), 32'd0);
        end

        n = 1;
        while (!bus.RespValid && n < 8) begin
            @(negedge CLK);
            n++;
        end
        chk("resp_valid",   32'(bus.RespValid), 32'd1);
        chk("resp_latency", 32'(n), 32'(exp_lat));
        chk("resp_rdata",   bus.RespRData, exp_data);
        chk("resp_exc",     32'(bus.RespExc), 32'(exp_exc));
        chk("resp_busy",    32'(bus.ReqReady), 32'd0);

        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            chk("hold_valid", 32'(bus.RespValid), 32'd1);
            chk("hold_rdata", bus.RespRData, exp_data);
            chk("hold_exc",   32'(bus.RespExc), 32'(exp_exc));
            chk("hold_busy",  32'(bus.ReqReady), 32'd0);
        end

        bus.RespReady = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.RespReady = 1'b0;
        inj_r = 1'b0;
        inj_w = 1'b0;
        chk("post_idle_ready", 32'(bus.ReqReady), 32'd1);
        chk("post_idle_valid", 32'(bus.RespValid), 32'd0);
    endtask

    // Word access accepted, reset asserted across its ACC edge.
    task automatic reset_in_acc(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge CLK);
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = wr;
        bus.ReqWHBS   = 2'b11;
        bus.ReqSigned = 1'b0;
        bus.ReqAddr   = addr;
        bus.ReqWData  = wd;
        @(posedge CLK);
        @(negedge CLK);
        bus.ReqValid = 1'b0;
        chk("rst_acc_we", 32'(bus.MemWE), 32'(wr));
        nRST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        chk("rst_abort_valid", 32'(bus.RespValid), 32'd0);
        chk("rst_abort_ready", 32'(bus.ReqReady), 32'd1);
        chk("rst_abort_exc",   32'(bus.RespExc), 32'd0);
        @(negedge CLK);
        chk("rst_no_resp",     32'(bus.RespValid), 32'd0);
        if (wr)
            for (int i = 0; i < 4; i++)
                model_mem[int'(addr) + i] = wd[8*i +: 8];
    endtask

    initial begin
        logic [31:0] a;
        int          r;

        for (int i = 0; i < RAM_BYTES; i++) begin
            ram[i]       = 8'($urandom);
            model_mem[i] = ram[i];
        end
        nRST          = 1'b0;
        bus.ReqValid  = 1'b0;
        bus.ReqWrite  = 1'b0;
        bus.ReqWHBS   = 2'b00;
        bus.ReqSigned = 1'b0;
        bus.ReqAddr   = 32'd0;
        bus.ReqWData  = 32'd0;
        bus.RespReady = 1'b0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", 32'(bus.ReqReady),  32'd1);
        chk("rst_valid", 32'(bus.RespValid), 32'd0);
        chk("rst_rdata", bus.RespRData,      32'd0);
        chk("rst_exc",   32'(bus.RespExc),   32'd0);
        chk("rst_we",    32'(bus.MemWE),     32'd0);
        nRST = 1'b1;

        xact(1'b1, 2'b11, 1'b0, 32'd0, 32'h1111_1111, 0, 1'b0);
        xact(1'b0, 2'b11, 1'b0, 32'd0, 32'd0,         0, 1'b0);

        xact(1'b1, 2'b11, 1'b0, 32'd8, 32'hA1B2_C3D4, 0, 1'b0);
        xact(1'b1, 2'b00, 1'b0, 32'd9, 32'h0000_00F5, 0, 1'b0);
        xact(1'b0, 2'b00, 1'b1, 32'd9, 32'd0, 0, 1'b0);
        xact(1'b0, 2'b00, 1'b0, 32'd9, 32'd0, 0, 1'b0);
        for (int i = 8; i < 12; i++)
            if (i != 9) xact(1'b0, 2'b00, 1'b0, 32'(i), 32'd0, 0, 1'b0);
        xact(1'b0, 2'b11, 1'b0, 32'd8, 32'd0, 0, 1'b0);

        xact(1'b0, 2'b01, 1'b0, 32'd5,    32'd0, 0, 1'b0);
        xact(1'b0, 2'b10, 1'b0, 32'd4,    32'd0, 0, 1'b0);
        xact(1'b1, 2'b10, 1'b0, 32'd5,    32'd0, 0, 1'b0);
        xact(1'b0, 2'b11, 1'b0, 32'd1022, 32'd0, 0, 1'b0);
        xact(1'b0, 2'b01, 1'b1, 32'd1022, 32'd0, 0, 1'b0);
        xact(1'b0, 2'b00, 1'b0, 32'd1024, 32'd0, 0, 1'b0);
        xact(1'b0, 2'b11, 1'b0, 32'd1020, 32'd0, 0, 1'b0);
        xact(1'b1, 2'b01, 1'b0, 32'd1023, 32'd0, 0, 1'b0);

        xact(1'b0, 2'b11, 1'b0, 32'd0, 32'd0, 5, 1'b0);
        xact(1'b1, 2'b01, 1'b0, 32'd2, 32'h0000_8765, 5, 1'b0);
        xact(1'b0, 2'b01, 1'b1, 32'd2, 32'd0, 0, 1'b0);

        xact(1'b0, 2'b11, 1'b0, 32'd16, 32'd0,         0, 1'b1);
        xact(1'b1, 2'b11, 1'b0, 32'd16, 32'hDEAD_BEEF, 0, 1'b1);
        xact(1'b0, 2'b11, 1'b0, 32'd16, 32'd0,         0, 1'b0);

        reset_in_acc(1'b0, 32'd0, 32'd0);
        xact(1'b0, 2'b11, 1'b0, 32'd0, 32'd0, 0, 1'b0);
        reset_in_acc(1'b1, 32'd32, 32'hCAFE_F00D);
        xact(1'b0, 2'b11, 1'b0, 32'd32, 32'd0, 0, 1'b0);

        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(1016 + $urandom_range(0, 11));
            else             a = 32'($urandom_range(0, RAM_BYTES - 1));
            xact(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                 $urandom_range(0, 2), $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
